// File: rtl/uart_tx_arbiter_if.sv
// Requester and serializer signals shared by the UART TX arbiter.
// The master side is the environment (byte producers plus serializer); the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_active;
  logic                 err_timeout;

  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_data, tx_start, grant_idx, grant_active, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_data, tx_start, grant_idx, grant_active, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX serializer among NUM_REQ byte producers.
// Bytes go out one at a time; a lock flag lets an owner keep the grant for a burst of up to MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDX_W        = 1,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic              clk,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);
  localparam int BST_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, nstate;
  logic [7:0]       tx_data_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [IDX_W-1:0] rr_ptr;
  logic             grant_active_q;
  logic             lock_q;
  logic [BST_W-1:0] burst_cnt;
  logic [CNT_W-1:0] tmo_cnt;

  logic [IDX_W-1:0] sel, cand;
  logic             sel_vld;
  logic [7:0]       sel_byte;
  logic             sel_lock;
  logic             accept, tmo, done, keep;

  // A held lock pins the choice to the current owner; otherwise search starts just past rr_ptr.
  always_comb begin
    sel     = grant_idx_q;
    sel_vld = 1'b0;
    cand    = '0;
    if (lock_q) begin
      sel_vld = bus.req_valid[grant_idx_q];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!sel_vld && bus.req_valid[cand]) begin
          sel     = cand;
          sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_byte = bus.req_data[i*8 +: 8];
        sel_lock = bus.req_lock[i];
      end
    end
  end

  assign accept = (state == ARB) && !bus.tx_busy && sel_vld;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
    assign bus.req_ready[g] = accept && (sel == IDX_W'(g));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    tmo    = 1'b0;
    done   = 1'b0;
    case (state)
      ARB:       if (accept) nstate = ISSUE;
      ISSUE:     nstate = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          nstate = WAIT_DONE;
        end else if (tmo_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          tmo    = 1'b1;
          nstate = ARB;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done   = 1'b1;
          nstate = ARB;
        end
      end
      default:   nstate = ARB;
    endcase
  end

  assign keep = lock_q && (burst_cnt < BST_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q      <= 8'h00;
      grant_idx_q    <= '0;
      grant_active_q <= 1'b0;
      lock_q         <= 1'b0;
      burst_cnt      <= '0;
      tmo_cnt        <= '0;
      rr_ptr         <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        tx_data_q      <= sel_byte;
        grant_idx_q    <= sel;
        grant_active_q <= 1'b1;
        lock_q         <= sel_lock;
      end
      if (state == ISSUE)                         tmo_cnt <= '0;
      else if (state == WAIT_BUSY && !bus.tx_busy) tmo_cnt <= tmo_cnt + CNT_W'(1);
      // A dead serializer forfeits the grant so the other requesters still make progress.
      if (tmo) begin
        lock_q         <= 1'b0;
        burst_cnt      <= '0;
        rr_ptr         <= grant_idx_q;
        grant_active_q <= 1'b0;
      end
      if (done) begin
        if (keep) begin
          burst_cnt <= burst_cnt + BST_W'(1);
        end else begin
          rr_ptr         <= grant_idx_q;
          burst_cnt      <= '0;
          lock_q         <= 1'b0;
          grant_active_q <= 1'b0;
        end
      end
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = (state == ISSUE);
  assign bus.grant_idx    = grant_idx_q;
  assign bus.grant_active = grant_active_q;
  assign bus.err_timeout  = tmo;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a serializer stand-in and a transaction-level model
// checked every cycle, plus literal byte-order and timing expectations per scenario.
module tb_uart_tx_arbiter;
  localparam int N      = 2;
  localparam int MAXB   = 4;
  localparam int BT     = 4;
  localparam int BYTE_T = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .IDX_W(1)) bus();
  uart_tx_arbiter #(.NUM_REQ(N), .IDX_W(1), .MAX_BURST(MAXB), .BUSY_TIMEOUT(BT))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0]  q0[$], q1[$];
  logic [15:0] log_q[$];
  int          t_start[$], t_tmo[$];
  logic [15:0] ex[8];
  bit pop0, pop1, ser_go, dead, foreign;
  int ser_left;

  // model state: what the arbiter must be doing according to the rules
  bit         m_in_flight, m_saw, m_lock, m_active;
  int         m_age, m_owner, m_last, m_burst;
  logic [7:0] m_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int   pick;
    logic [1:0] exp_rdy;
    bit   tmo, done, saw_next;
    if (!reset_n) begin
      m_in_flight = 0; m_saw = 0; m_lock = 0; m_active = 0;
      m_age = 0; m_owner = 0; m_last = N - 1; m_burst = 0; m_data = 8'h00;
      pop0 = 0; pop1 = 0; ser_go = 0;
      chk("rst_tx_start",     32'(bus.tx_start),     32'd0);
      chk("rst_tx_data",      32'(bus.tx_data),      32'd0);
      chk("rst_grant_idx",    32'(bus.grant_idx),    32'd0);
      chk("rst_grant_active", 32'(bus.grant_active), 32'd0);
      chk("rst_err_timeout",  32'(bus.err_timeout),  32'd0);
    end else begin
      pick = -1;
      if (!m_in_flight && !bus.tx_busy) begin
        if (m_lock) begin
          if (bus.req_valid[m_owner]) pick = m_owner;
        end else begin
          for (int k = 1; k <= N; k++)
            if (pick < 0 && bus.req_valid[(m_last + k) % N]) pick = (m_last + k) % N;
        end
      end
      exp_rdy = (pick >= 0) ? 2'(1 << pick) : 2'b00;
      tmo = 0; done = 0; saw_next = 0;
      if (m_in_flight && m_age >= 2) begin
        if (!m_saw) begin
          if (bus.tx_busy) saw_next = 1;
          else if (m_age == BT + 1) tmo = 1;
        end else if (!bus.tx_busy) begin
          done = 1;
        end
      end
      chk("req_ready",    32'(bus.req_ready),    32'(exp_rdy));
      chk("tx_start",     32'(bus.tx_start),     32'(m_in_flight && m_age == 1));
      chk("err_timeout",  32'(bus.err_timeout),  32'(tmo));
      chk("tx_data",      32'(bus.tx_data),      32'(m_data));
      chk("grant_idx",    32'(bus.grant_idx),    32'(m_owner));
      chk("grant_active", 32'(bus.grant_active), 32'(m_active));

      pop0   = bus.req_valid[0] && bus.req_ready[0];
      pop1   = bus.req_valid[1] && bus.req_ready[1];
      ser_go = bus.tx_start && !dead;
      if (bus.tx_start) begin
        log_q.push_back({7'b0, bus.grant_idx, bus.tx_data});
        t_start.push_back(cyc);
      end
      if (bus.err_timeout) t_tmo.push_back(cyc);

      if (m_in_flight) begin
        m_age++;
        if (saw_next) m_saw = 1;
        if (tmo) begin
          m_lock = 0; m_burst = 0; m_last = m_owner; m_active = 0; m_in_flight = 0;
        end
        if (done) begin
          if (m_lock && m_burst < MAXB - 1) m_burst++;
          else begin
            m_last = m_owner; m_burst = 0; m_lock = 0; m_active = 0;
          end
          m_in_flight = 0;
        end
      end
      if (pick >= 0) begin
        m_in_flight = 1; m_age = 1; m_saw = 0; m_owner = pick; m_active = 1;
        m_data = bus.req_data[pick*8 +: 8];
        m_lock = bus.req_lock[pick];
      end
    end
  end

  // one clock of environment: apply accepted pops, advance the serializer, present queue heads
  task automatic step();
    @(posedge clk); #1;
    if (pop0 && q0.size() > 0) void'(q0.pop_front());
    if (pop1 && q1.size() > 0) void'(q1.pop_front());
    if (ser_go) ser_left = BYTE_T;
    bus.tx_busy = (ser_left > 0) || foreign;
    if (ser_left > 0) ser_left--;
    bus.req_valid      = {q1.size() > 0, q0.size() > 0};
    bus.req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.req_lock[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
    bus.req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    bus.req_lock[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !m_in_flight && !bus.tx_busy) && n < 3000) begin
      step();
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL drain_%s: still busy after %0d cycles, want idle", nm, n);
    end
    run(3);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    step();
    log_q.delete(); t_start.delete(); t_tmo.delete();
  endtask

  task automatic check_log(input string nm, input int n);
    chk({nm, "_count"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(log_q[i]), 32'(ex[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_lock = '0; bus.tx_busy = 1'b0;
    dead = 0; foreign = 0; ser_left = 0;
    do_reset();

    // 1: single byte from req0, ready in the same cycle, start the next cycle
    q0.push_back({1'b0, 8'h41});
    step();
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    step();
    @(negedge clk);
    chk("t1_start", 32'(bus.tx_start), 32'h1);
    chk("t1_data",  32'(bus.tx_data),  32'h41);
    chk("t1_grant", 32'(bus.grant_idx), 32'h0);
    drain("t1");
    ex = '{16'h0041, 0, 0, 0, 0, 0, 0, 0};
    check_log("t1", 1);

    // 2: contention without lock alternates, req0 first
    do_reset();
    q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b0, 8'hA0});
    q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b0, 8'hB0});
    drain("t2");
    ex = '{16'h00A0, 16'h01B0, 16'h00A0, 16'h01B0, 0, 0, 0, 0};
    check_log("t2", 4);

    // 3: req1 locked burst of three, req0 waits
    do_reset();
    q1.push_back({1'b1, 8'hC1}); q1.push_back({1'b1, 8'hC2}); q1.push_back({1'b0, 8'hC3});
    run(3);
    q0.push_back({1'b0, 8'hD0});
    drain("t3");
    ex = '{16'h01C1, 16'h01C2, 16'h01C3, 16'h00D0, 0, 0, 0, 0};
    check_log("t3", 4);

    // 4: burst cap of 4 forces rotation to req0, then req1 resumes
    do_reset();
    q1.push_back({1'b1, 8'h11}); q1.push_back({1'b1, 8'h12}); q1.push_back({1'b1, 8'h13});
    q1.push_back({1'b1, 8'h14}); q1.push_back({1'b1, 8'h15}); q1.push_back({1'b0, 8'h16});
    run(3);
    q0.push_back({1'b0, 8'hA5});
    drain("t4");
    ex = '{16'h0111, 16'h0112, 16'h0113, 16'h0114, 16'h00A5, 16'h0115, 16'h0116, 0};
    check_log("t4", 7);

    // 5: reset during WAIT_DONE drops the byte; next grant goes to req0
    do_reset();
    q0.push_back({1'b0, 8'h55});
    run(4);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_active", 32'(bus.grant_active), 32'h0);
    chk("t5_rst_data",   32'(bus.tx_data),      32'h0);
    step();
    reset_n = 1'b1;
    log_q.delete();
    q1.push_back({1'b0, 8'h66});
    q0.push_back({1'b0, 8'h77});
    drain("t5");
    ex = '{16'h0077, 16'h0166, 0, 0, 0, 0, 0, 0};
    check_log("t5", 2);

    // 6: dead serializer times out four cycles after start and rotates
    do_reset();
    dead = 1;
    q0.push_back({1'b1, 8'hE0});
    q1.push_back({1'b0, 8'hE1});
    drain("t6");
    dead = 0;
    ex = '{16'h00E0, 16'h01E1, 0, 0, 0, 0, 0, 0};
    check_log("t6", 2);
    chk("t6_tmo_count", 32'(t_tmo.size()), 32'd2);
    if (t_tmo.size() > 0 && t_start.size() > 0)
      chk("t6_tmo_delay", 32'(t_tmo[0] - t_start[0]), 32'd4);

    // 7: stale busy in ARB holds off any grant until it drops
    log_q.delete();
    foreign = 1;
    q0.push_back({1'b0, 8'h99});
    run(8);
    @(negedge clk);
    chk("t7_held_ready", 32'(bus.req_ready), 32'h0);
    chk("t7_held_count", 32'(log_q.size()), 32'd0);
    foreign = 0;
    drain("t7");
    ex = '{16'h0099, 0, 0, 0, 0, 0, 0, 0};
    check_log("t7", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
